// File: rtl/k_and_s_pkg.sv
// K&S processor shared types: instruction decode, control states, ALU ops.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH,
    LATCH_IR,
    DECODE,
    LOAD_WAIT,
    LOAD_WR,
    STORE,
    MOVE,
    ALU,
    BRANCH,
    HALT,
    PAUSE
  } ctrl_state_type;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  function automatic logic [1:0] alu_op(
    input decoded_instruction_type i
  );
    case (i)
      I_ADD:   return ALU_ADD;
      I_SUB:   return ALU_SUB;
      I_AND:   return ALU_AND;
      default: return ALU_OR;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond.sv
// K&S branch condition: decoded instruction plus flags to "taken".
module branch_cond
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  output logic                    taken
);

  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = unsigned_overflow;
      I_BNOV:   taken = !unsigned_overflow;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// K&S control unit: Moore FSM sequencing fetch, decode and execute.
// Optional single-step mode via KS_SINGLE_STEP_EN (adds step input).
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef KS_SINGLE_STEP_EN
  input  logic                    step,
`endif
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  localparam bit NO_WAIT = (MEM_WAIT_CYCLES == 0);
  localparam ctrl_state_type FETCH_ST = NO_WAIT ? LATCH_IR : FETCH;
  localparam ctrl_state_type LOAD_ST  = NO_WAIT ? LOAD_WR : LOAD_WAIT;
  localparam logic [2:0] WAIT_LAST =
    3'(NO_WAIT ? 0 : MEM_WAIT_CYCLES - 1);

  ctrl_state_type state, state_next, after_exec;
  logic [2:0]     wait_cnt;
  logic           wait_done;
  logic           taken;
  logic           unused_flags;

  // No branch tests the signed-overflow flag.
  assign unused_flags = signed_overflow;
  assign wait_done    = (wait_cnt == WAIT_LAST);

`ifdef KS_SINGLE_STEP_EN
  assign after_exec = PAUSE;
`else
  assign after_exec = FETCH_ST;
`endif

  branch_cond u_branch_cond (
    .decoded_instruction(decoded_instruction),
    .zero_op            (zero_op),
    .neg_op             (neg_op),
    .unsigned_overflow  (unsigned_overflow),
    .taken              (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_ST;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state_next != state) ? 3'd0 : wait_cnt + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:     if (wait_done) state_next = LATCH_IR;
      LATCH_IR:  state_next = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:  state_next = LOAD_ST;
          I_STORE: state_next = STORE;
          I_MOVE:  state_next = MOVE;
          I_ADD, I_SUB, I_AND, I_OR:
                   state_next = ALU;
          I_BRANCH, I_BZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:
                   state_next = BRANCH;
          I_HALT:  state_next = HALT;
          default: state_next = after_exec;
        endcase
      end
      LOAD_WAIT: if (wait_done) state_next = LOAD_WR;
      LOAD_WR,
      STORE,
      MOVE,
      ALU,
      BRANCH:    state_next = after_exec;
      HALT:      state_next = HALT;
`ifdef KS_SINGLE_STEP_EN
      PAUSE:     if (step) state_next = FETCH_ST;
`endif
      default:   state_next = FETCH_ST;
    endcase
  end

  // Outputs are forced low during reset, even mid-instruction.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      case (state)
        LATCH_IR:  ir_enable = 1'b1;
        DECODE:    pc_enable = 1'b1;
        LOAD_WAIT: addr_sel = 1'b1;
        LOAD_WR: begin
          addr_sel         = 1'b1;
          write_reg_enable = 1'b1;
        end
        STORE: begin
          addr_sel         = 1'b1;
          ram_write_enable = 1'b1;
        end
        MOVE: begin
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
        end
        ALU: begin
          operation        = alu_op(decoded_instruction);
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          flags_reg_enable = 1'b1;
        end
        BRANCH: begin
          branch    = taken;
          pc_enable = taken;
        end
        HALT:      halt = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit (default and 3-wait RAM).
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam logic [10:0] BR = 11'h400;
  localparam logic [10:0] PC = 11'h200;
  localparam logic [10:0] IR = 11'h100;
  localparam logic [10:0] AS = 11'h080;
  localparam logic [10:0] CS = 11'h040;
  localparam logic [10:0] WR = 11'h008;
  localparam logic [10:0] FL = 11'h004;
  localparam logic [10:0] RW = 11'h002;
  localparam logic [10:0] HT = 11'h001;
  localparam logic [10:0] OP_ADD = 11'h010;
  localparam logic [10:0] OP_SUB = 11'h020;
  localparam logic [10:0] OP_AND = 11'h030;
  localparam logic [10:0] ALU_V = CS | WR | FL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b1;
  decoded_instruction_type di = I_NOP;
  logic z = 1'b0, n = 1'b0, uo = 1'b0, so = 1'b0;

  logic       br1, pc1, ir1, as1, cs1, wr1, fl1, rw1, ht1;
  logic [1:0] op1;
  logic       br3, pc3, ir3, as3, cs3, wr3, fl3, rw3, ht3;
  logic [1:0] op3;
  logic [10:0] o1, o3;

  int vecs = 0;
  int errs = 0;

  assign o1 = {br1, pc1, ir1, as1, cs1, op1, wr1, fl1, rw1, ht1};
  assign o3 = {br3, pc3, ir3, as3, cs3, op3, wr3, fl3, rw3, ht3};

  always #5 clk = ~clk;

  control_unit dut (
    .clk                (clk),
    .rst                (rst),
`ifdef KS_SINGLE_STEP_EN
    .step               (step),
`endif
    .decoded_instruction(di),
    .zero_op            (z),
    .neg_op             (n),
    .unsigned_overflow  (uo),
    .signed_overflow    (so),
    .branch             (br1),
    .pc_enable          (pc1),
    .ir_enable          (ir1),
    .addr_sel           (as1),
    .c_sel              (cs1),
    .operation          (op1),
    .write_reg_enable   (wr1),
    .flags_reg_enable   (fl1),
    .ram_write_enable   (rw1),
    .halt               (ht1)
  );

  control_unit #(.MEM_WAIT_CYCLES(3)) dut3 (
    .clk                (clk),
    .rst                (rst),
`ifdef KS_SINGLE_STEP_EN
    .step               (step),
`endif
    .decoded_instruction(di),
    .zero_op            (z),
    .neg_op             (n),
    .unsigned_overflow  (uo),
    .signed_overflow    (so),
    .branch             (br3),
    .pc_enable          (pc3),
    .ir_enable          (ir3),
    .addr_sel           (as3),
    .c_sel              (cs3),
    .operation          (op3),
    .write_reg_enable   (wr3),
    .flags_reg_enable   (fl3),
    .ram_write_enable   (rw3),
    .halt               (ht3)
  );

  task automatic check(input string tag,
                       input logic [10:0] got,
                       input logic [10:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  // Holds reset 3 cycles, releases it; leaves the DUTs in cycle 1 (FETCH).
  task automatic do_reset(input decoded_instruction_type i);
    di  = i;
    rst = 1'b1;
    repeat (3) begin
      cyc;
      check("rst_out", o1, 11'h0);
      check("rst_out3", o3, 11'h0);
    end
    rst = 1'b0;
    #1;
    check("fetch_c1", o1, 11'h0);
  endtask

  task automatic run4(input string tag,
                      input decoded_instruction_type i,
                      input logic [10:0] exp4);
    do_reset(i);
    cyc; check({tag, "_c2"}, o1, IR);
    cyc; check({tag, "_c3"}, o1, PC);
    cyc; check({tag, "_c4"}, o1, exp4);
    cyc; check({tag, "_c5"}, o1, 11'h0);
  endtask

  logic [10:0] exp_l1 [6];
  logic [10:0] exp_l3 [10];

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran away");
    $fatal(1);
  end

  initial begin
    run4("add", I_ADD, ALU_V | OP_ADD);
    run4("sub", I_SUB, ALU_V | OP_SUB);
    run4("and", I_AND, ALU_V | OP_AND);
    run4("or", I_OR, ALU_V);
    run4("move", I_MOVE, CS | WR);
    run4("store", I_STORE, AS | RW);

    z = 1'b1;
    run4("bzero_t", I_BZERO, BR | PC);
    z = 1'b0;
    run4("bzero_nt", I_BZERO, 11'h0);
    n = 1'b0;
    run4("bnneg_t", I_BNNEG, BR | PC);
    run4("bneg_nt", I_BNEG, 11'h0);
    uo = 1'b1;
    run4("bov_t", I_BOV, BR | PC);
    run4("bnov_nt", I_BNOV, 11'h0);
    run4("bra_t", I_BRANCH, BR | PC);
    uo = 1'b0;

    do_reset(I_NOP);
    cyc; check("nop_c2", o1, IR);
    cyc; check("nop_c3", o1, PC);
    cyc; check("nop_c4", o1, 11'h0);

    // LOAD on both DUTs: 1-wait finishes at c5, 3-wait at c9.
    exp_l1 = '{11'h0, IR, PC, AS, AS | WR, 11'h0};
    exp_l3 = '{11'h0, 11'h0, 11'h0, IR, PC,
               AS, AS, AS, AS | WR, 11'h0};
    do_reset(I_LOAD);
    check("load3_c1", o3, exp_l3[0]);
    for (int c = 1; c < 10; c++) begin
      cyc;
      if (c < 6) check($sformatf("load1_c%0d", c + 1), o1, exp_l1[c]);
      check($sformatf("load3_c%0d", c + 1), o3, exp_l3[c]);
    end

    do_reset(I_STORE);
    cyc; cyc; cyc;
    check("store_c4", o1, AS | RW);
    rst = 1'b1;
    #1;
    check("store_rst", o1, 11'h0);
    cyc;
    check("store_rst2", o1, 11'h0);

    do_reset(I_HALT);
    cyc; cyc;
    for (int c = 0; c < 20; c++) begin
      cyc;
      check($sformatf("halt_%0d", c), o1, HT);
    end
    rst = 1'b1;
    #1;
    check("halt_rst", o1, 11'h0);
    cyc;
    check("halt_rst2", o1, 11'h0);

`ifdef KS_SINGLE_STEP_EN
    step = 1'b0;
    do_reset(I_MOVE);
    cyc; check("ss_c2", o1, IR);
    cyc; check("ss_c3", o1, PC);
    cyc; check("ss_c4", o1, CS | WR);
    cyc; check("ss_pause1", o1, 11'h0);
    cyc; check("ss_pause2", o1, 11'h0);
    step = 1'b1;
    cyc; check("ss_fetch", o1, 11'h0);
    step = 1'b0;
    cyc; check("ss_latch", o1, IR);
    step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM that sequences the K&S processor's data path: fetch, decode, execute.
- Consumes decoded_instruction and the four registered flags from the data path.
- Drives every data-path enable/select, plus the RAM write strobe and a halt indication.
- Sits beside the data path in the top-level core; the RAM is the third party on the bus.

Parameters:
- MEM_WAIT_CYCLES, 1: RAM read wait cycles before data_in is valid (legal 0..7); applies to instruction fetch and LOAD.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- decoded_instruction  in  decoded_instruction_type  current IR decode
- zero_op  in  1  registered zero flag
- neg_op  in  1  registered negative flag
- unsigned_overflow  in  1  registered carry-out flag
- signed_overflow  in  1  registered signed-overflow flag
- branch  out  1  PC loads the instruction address field instead of PC+1
- pc_enable  out  1  PC update strobe
- ir_enable  out  1  IR load strobe
- addr_sel  out  1  0: RAM address = PC; 1: RAM address = instruction field
- c_sel  out  1  0: register write data = RAM data_in; 1: ALU result
- operation  out  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- write_reg_enable  out  1  register file write strobe
- flags_reg_enable  out  1  flag register load strobe
- ram_write_enable  out  1  RAM write strobe (data_out written at ram_addr)
- halt  out  1  processor halted

Behaviour:
- Outputs are decoded combinationally from the state register. Unlisted outputs are 0 in every state.
- While rst is high, all outputs are 0. The state moves to FETCH, or to LATCH_IR when MEM_WAIT_CYCLES = 0, and wait_cnt clears.
- Reset wins over every other event, including mid-instruction. An interrupted STORE has ram_write_enable low from the same edge on.
- FETCH:
  - addr_sel = 0.
  - Held for exactly MEM_WAIT_CYCLES cycles, counted by wait_cnt (3 bits, cleared on every state entry), then goes to LATCH_IR.
- LATCH_IR: addr_sel = 0, ir_enable = 1; goes to DECODE.
- DECODE:
  - pc_enable = 1, branch = 0, so PC advances by 1 for every instruction.
  - Next state by decoded_instruction:
    - I_LOAD: LOAD_WAIT, or LOAD_WR if MEM_WAIT_CYCLES = 0.
    - I_STORE: STORE.
    - I_MOVE: MOVE.
    - I_ADD, I_SUB, I_AND, I_OR: ALU.
    - Any branch instruction: BRANCH.
    - I_HALT: HALT.
    - I_NOP or any other value: FETCH.
- LOAD_WAIT: addr_sel = 1; held MEM_WAIT_CYCLES cycles, then LOAD_WR.
- LOAD_WR: addr_sel = 1, c_sel = 0, write_reg_enable = 1; goes to FETCH.
- STORE: addr_sel = 1, ram_write_enable = 1 for exactly one cycle; goes to FETCH.
- MOVE:
  - operation = 00, c_sel = 1, write_reg_enable = 1, flags_reg_enable = 0; goes to FETCH.
  - The OR of the source with itself copies the source register.
- ALU:
  - operation is 01 for ADD, 10 for SUB, 11 for AND, 00 for OR.
  - c_sel = 1, write_reg_enable = 1, flags_reg_enable = 1; goes to FETCH.
- BRANCH:
  - If the condition holds, branch = 1 and pc_enable = 1; otherwise all outputs stay 0. Goes to FETCH.
  - Conditions: I_BRANCH always; I_BZERO zero_op; I_BNEG neg_op; I_BNNEG !neg_op; I_BOV unsigned_overflow; I_BNOV !unsigned_overflow.
  - Flags are sampled in the BRANCH cycle. Flags always come from the most recent ALU op, because no other state enables the flag register.
- HALT: halt = 1; absorbing until rst.
- IR is only loaded in LATCH_IR, so decoded_instruction is stable from DECODE through the execute state.
- Cycle counts per instruction with the default parameter:
  - NOP: 3
  - STORE, MOVE, ALU, BRANCH: 4
  - LOAD: 5

Optional Feature:
- Macro: KS_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - Every execute state, and DECODE for NOP, goes to a PAUSE state instead of the normal successor. All outputs are 0 in PAUSE.
  - PAUSE goes to the normal successor on the first cycle step = 1; a held step advances one instruction per PAUSE visit.
  - HALT is unaffected.
- Undefined: no step port and no PAUSE state; timing exactly as above.

Decomposition:
- k_and_s_pkg gains:
  - ctrl_state_type enum: FETCH, LATCH_IR, DECODE, LOAD_WAIT, LOAD_WR, STORE, MOVE, ALU, BRANCH, HALT, PAUSE.
  - ALU op constants: ALU_OR = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10, ALU_AND = 2'b11.
  - decoded_instruction_type is reused unchanged.
- One natural sub-module: branch_cond, a purely combinational map of decoded instruction plus flags to "taken".

Test Plan:
- Reset: rst high for 3 cycles, then low → all outputs 0 during reset; first post-reset cycle is FETCH with addr_sel = 0; ir_enable = 1 on cycle 2.
- ADD with default parameter → ir_enable in cycle 2, pc_enable in cycle 3; cycle 4 has operation = 01, c_sel = 1, write_reg_enable = 1, flags_reg_enable = 1.
- LOAD with MEM_WAIT_CYCLES = 3 → addr_sel = 1 for 4 cycles; write_reg_enable = 1 with c_sel = 0 only in the last; next FETCH follows.
- BZERO with zero_op = 1, then zero_op = 0 → first: branch = 1 and pc_enable = 1 in the BRANCH cycle; second: both stay 0 in that cycle.
- HALT → halt = 1 held for 20 cycles with no strobes; rst asserted → halt = 0 on the next edge.
- KS_SINGLE_STEP_EN with step = 0 after a MOVE → FSM parks in PAUSE with all outputs 0; a one-cycle step pulse → FETCH on the next edge.
